claw_sequencer: RTL and testbench
=================================

CLAW_SEQUENCER -- requirements
Module: claw_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, max cycles allowed in EXTEND or RETRACT before fault.
REQ-002 SHALL have parameter GRIP_CYCLES, default 50, grip-close settle time in cycles.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port extend_claws  input  1  pick request level from claw controller.
REQ-007 SHALL have port stop  input  1  robot-halted qualifier from claw controller.
REQ-008 SHALL have ports limit_ext, limit_ret  input  1 each  arm fully-extended and fully-retracted switches.
REQ-009 SHALL have port grip_sensor  input  1  box present between jaws.
REQ-010 SHALL have ports motor_extend, motor_retract, grip_close  output  1 each  actuator drives.
REQ-011 SHALL have ports pick_done, pick_fail, busy  output  1 each  status back to the navigation FSM.
REQ-012 SHALL have port seq_state  output  3  current state code.

Function
REQ-013 SHALL implement states IDLE=0, EXTEND=1, GRIP=2, RETRACT=3, DONE=4, FAULT=5; all outputs are Moore-decoded from the registered state.
REQ-014 SHALL leave IDLE for EXTEND when extend_claws=1 and stop=1 are sampled together; motor_extend goes high on the following cycle.
REQ-015 SHALL drive motor_extend=1 only in EXTEND, and move to GRIP on limit_ext=1.
REQ-016 SHALL drive grip_close=1 in GRIP, RETRACT and DONE, and hold GRIP for exactly GRIP_CYCLES cycles.
REQ-017 SHALL, at the end of GRIP, go to RETRACT if grip_sensor=1, else to FAULT.
REQ-018 SHALL drive motor_retract=1 only in RETRACT, and move to DONE on limit_ret=1.
REQ-019 SHALL clear the phase counter on every state entry; reaching TIMEOUT_CYCLES in EXTEND or RETRACT with no limit switch SHALL go to FAULT.
REQ-020 SHALL go to FAULT if grip_sensor drops in RETRACT (box slipped).
REQ-021 SHALL go to FAULT if limit_ext=1 and limit_ret=1 in the same cycle, in any non-IDLE state.
REQ-022 SHALL, when stop drops in EXTEND or GRIP, abort to RETRACT with grip_close=0, then end in FAULT on limit_ret.
REQ-023 SHALL hold DONE with pick_done=1 until extend_claws=0 (four-phase handshake), then return to IDLE.
REQ-024 SHALL hold FAULT with pick_fail=1 and all drives 0 until extend_claws=0, then return to IDLE.
REQ-025 SHALL assert busy in every state except IDLE.
REQ-026 SHALL never assert motor_extend and motor_retract in the same cycle.
REQ-027 SHALL, when a limit switch is already asserted on state entry, transition on the next cycle.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, force IDLE, clear the counter and retry flag, and drive every output to 0, including mid-sequence.

Configuration
REQ-029 SHALL, with CLAW_RETRY_EN defined, handle the first grip failure of a sequence by re-entering GRIP once with the counter cleared and grip_close low for 1 cycle; a second failure goes to FAULT.
REQ-030 SHALL, without CLAW_RETRY_EN defined, send the first grip failure directly to FAULT, and omit the retry flag.

Structure
REQ-031 SHALL place the state encodings and the PICK_BOX code 3'b101 in shared package claw_pkg.
REQ-032 SHALL implement the phase counter as sub-module phase_timer, with clear and enable inputs and a terminal-count output.

Verification (TIMEOUT_CYCLES=16, GRIP_CYCLES=4)
REQ-033 SHALL cover the nominal pick: request+stop, limit_ext after 5 cycles, grip_sensor=1, limit_ret after 6 cycles -> pick_done=1; IDLE 1 cycle after extend_claws=0.
REQ-034 SHALL cover EXTEND timeout: no limit_ext for 16 cycles -> FAULT, pick_fail=1, all drives 0.
REQ-035 SHALL cover grip miss: grip_sensor=0 -> FAULT after 4 GRIP cycles; with CLAW_RETRY_EN, FAULT only after a second 4-cycle attempt.
REQ-036 SHALL cover stop dropped during EXTEND: -> RETRACT with grip_close=0, then FAULT on limit_ret.
REQ-037 SHALL cover rst=1 in RETRACT: next cycle seq_state=0 and all outputs 0; both limits high in EXTEND -> FAULT next cycle.

Source files
------------

// File: rtl/claw_pkg.sv
// Shared claw definitions: sequencer state codes and the navigation command
// code that requests a pick.
package claw_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXTEND  = 3'd1,
    S_GRIP    = 3'd2,
    S_RETRACT = 3'd3,
    S_DONE    = 3'd4,
    S_FAULT   = 3'd5
  } claw_state_e;

  localparam logic [2:0] PICK_BOX = 3'b101;

endpackage

// File: rtl/claw_sequencer_phase_timer.sv
// phase_timer: per-phase cycle counter. Cleared on every state entry,
// counts while enabled and saturates at the terminal count. tc is high
// in the tc_val-th cycle after a clear (count == tc_val-1).
module phase_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == (tc_val - W'(1)));

  // Count up while enabled, hold at terminal count, clear on request.
  always_ff @(posedge clk) begin
    if (rst || clear)        cnt <= '0;
    else if (enable && !tc)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/claw_sequencer.sv
// claw_sequencer: extend / grip / retract sequencer for the box claw.
// Optional feature: define CLAW_RETRY_EN to allow a single re-grip after
// the first grip miss of a sequence (default build: first miss faults).
import claw_pkg::*;

module claw_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int GRIP_CYCLES    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       extend_claws,
  input  logic       stop,
  input  logic       limit_ext,
  input  logic       limit_ret,
  input  logic       grip_sensor,
  output logic       motor_extend,
  output logic       motor_retract,
  output logic       grip_close,
  output logic       pick_done,
  output logic       pick_fail,
  output logic       busy,
  output logic [2:0] seq_state
);

  localparam int MAXC = (TIMEOUT_CYCLES > GRIP_CYCLES) ? TIMEOUT_CYCLES : GRIP_CYCLES;
  localparam int W    = $clog2(MAXC + 1);

  claw_state_e state, nxt;
  logic        abort_q, abort_d;   // retract was caused by stop dropping
  logic        restart;            // re-grip: clear timer without state change
  logic        tc, tmr_en, tmr_clr;
  logic [W-1:0] tc_val;
`ifdef CLAW_RETRY_EN
  logic        retry_q, retry_d;   // re-grip already used this sequence
  logic        regrip_q, regrip_d; // first cycle of the re-grip: jaws open
`endif

  assign tc_val  = (state == S_GRIP) ? W'(GRIP_CYCLES) : W'(TIMEOUT_CYCLES);
  assign tmr_en  = (state == S_EXTEND) || (state == S_GRIP) || (state == S_RETRACT);
  assign tmr_clr = (nxt != state) || restart;

  phase_timer #(.W(W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .tc_val (tc_val),
    .tc     (tc)
  );

  // State and sequence flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      abort_q  <= 1'b0;
`ifdef CLAW_RETRY_EN
      retry_q  <= 1'b0;
      regrip_q <= 1'b0;
`endif
    end else begin
      state    <= nxt;
      abort_q  <= abort_d;
`ifdef CLAW_RETRY_EN
      retry_q  <= retry_d;
      regrip_q <= regrip_d;
`endif
    end
  end

  // Next state, flag updates and Moore-decoded outputs.
  always_comb begin
    nxt           = state;
    abort_d       = abort_q;
    restart       = 1'b0;
`ifdef CLAW_RETRY_EN
    retry_d       = retry_q;
    regrip_d      = 1'b0;
`endif
    motor_extend  = 1'b0;
    motor_retract = 1'b0;
    grip_close    = 1'b0;
    pick_done     = 1'b0;
    pick_fail     = 1'b0;
    busy          = (state != S_IDLE);
    seq_state     = state;

    // Both limits at once means a broken switch: fault from anywhere active.
    if (state != S_IDLE && limit_ext && limit_ret) begin
      nxt = S_FAULT;
    end else begin
      case (state)
        S_IDLE: begin
          abort_d = 1'b0;
`ifdef CLAW_RETRY_EN
          retry_d = 1'b0;
`endif
          if (extend_claws && stop) nxt = S_EXTEND;
        end
        S_EXTEND: begin
          if (!stop) begin
            nxt     = S_RETRACT;
            abort_d = 1'b1;
          end else if (limit_ext) nxt = S_GRIP;
          else if (tc)            nxt = S_FAULT;
        end
        S_GRIP: begin
          if (!stop) begin
            nxt     = S_RETRACT;
            abort_d = 1'b1;
          end else if (tc) begin
            if (grip_sensor) nxt = S_RETRACT;
`ifdef CLAW_RETRY_EN
            else if (!retry_q) begin
              restart  = 1'b1;
              retry_d  = 1'b1;
              regrip_d = 1'b1;
            end
`endif
            else nxt = S_FAULT;
          end
        end
        S_RETRACT: begin
          // Slip only matters when we are actually carrying a box.
          if (!abort_q && !grip_sensor) nxt = S_FAULT;
          else if (limit_ret)           nxt = abort_q ? S_FAULT : S_DONE;
          else if (tc)                  nxt = S_FAULT;
        end
        S_DONE:  if (!extend_claws) nxt = S_IDLE;
        S_FAULT: if (!extend_claws) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end

    case (state)
      S_EXTEND:  motor_extend  = 1'b1;
      S_GRIP: begin
`ifdef CLAW_RETRY_EN
        grip_close = !regrip_q;
`else
        grip_close = 1'b1;
`endif
      end
      S_RETRACT: begin
        motor_retract = 1'b1;
        grip_close    = !abort_q;
      end
      S_DONE: begin
        grip_close = 1'b1;
        pick_done  = 1'b1;
      end
      S_FAULT:   pick_fail = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_claw_sequencer.sv
// Directed bench for claw_sequencer (TIMEOUT_CYCLES=16, GRIP_CYCLES=4).
module tb_claw_sequencer;

  logic       clk = 1'b0;
  logic       rst, extend_claws, stop, limit_ext, limit_ret, grip_sensor;
  logic       motor_extend, motor_retract, grip_close, pick_done, pick_fail, busy;
  logic [2:0] seq_state;
  int         total = 0;
  int         bad   = 0;

  claw_sequencer #(.TIMEOUT_CYCLES(16), .GRIP_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .extend_claws  (extend_claws),
    .stop          (stop),
    .limit_ext     (limit_ext),
    .limit_ret     (limit_ret),
    .grip_sensor   (grip_sensor),
    .motor_extend  (motor_extend),
    .motor_retract (motor_retract),
    .grip_close    (grip_close),
    .pick_done     (pick_done),
    .pick_fail     (pick_fail),
    .busy          (busy),
    .seq_state     (seq_state)
  );

  always #5 clk = ~clk;

  // outs = {me, mr, gc, pd, pf, busy}
  function automatic logic [7:0] outs();
    return {2'b00, motor_extend, motor_retract, grip_close, pick_done, pick_fail, busy};
  endfunction

  function automatic logic [7:0] st();
    return {5'b0, seq_state};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; inputs set after return are sampled at the next edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1; extend_claws = 0; stop = 0; limit_ext = 0; limit_ret = 0; grip_sensor = 0;
    step(2);
    chk("rst_state", st(), 8'h0);
    chk("rst_outs",  outs(), 8'h00);
    rst = 0;

    // Nominal pick
    extend_claws = 1; stop = 1;
    step();
    chk("nom_extend", st(), 8'h1);
    chk("nom_ext_outs", outs(), 8'h21);
    step(4);
    limit_ext = 1;
    step();
    chk("nom_grip", st(), 8'h2);
    chk("nom_grip_outs", outs(), 8'h09);
    limit_ext = 0; grip_sensor = 1;
    step(3);
    chk("nom_grip_hold", st(), 8'h2);
    step();
    chk("nom_retract", st(), 8'h3);
    chk("nom_ret_outs", outs(), 8'h19);
    step(5);
    limit_ret = 1;
    step();
    chk("nom_done", st(), 8'h4);
    chk("nom_done_outs", outs(), 8'h0d);
    step();
    chk("nom_done_hold", st(), 8'h4);
    extend_claws = 0; limit_ret = 0; grip_sensor = 0;
    step();
    chk("nom_idle", st(), 8'h0);
    chk("nom_idle_outs", outs(), 8'h00);

    // EXTEND timeout
    extend_claws = 1; stop = 1;
    step();
    step(15);
    chk("to_ext_last", st(), 8'h1);
    step();
    chk("to_fault", st(), 8'h5);
    chk("to_fault_outs", outs(), 8'h03);
    step();
    chk("to_fault_hold", st(), 8'h5);
    extend_claws = 0;
    step();
    chk("to_idle", st(), 8'h0);

    // Grip miss
    extend_claws = 1; stop = 1;
    step();
    limit_ext = 1;
    step();
    chk("gm_grip", st(), 8'h2);
    limit_ext = 0; grip_sensor = 0;
    step(3);
    chk("gm_grip_hold", st(), 8'h2);
    step();
`ifdef CLAW_RETRY_EN
    chk("gm_regrip", st(), 8'h2);
    chk("gm_regrip_open", outs(), 8'h01);
    step();
    chk("gm_regrip_close", outs(), 8'h09);
    step(2);
    chk("gm_regrip_hold", st(), 8'h2);
    step();
`endif
    chk("gm_fault", st(), 8'h5);
    chk("gm_fault_outs", outs(), 8'h03);
    extend_claws = 0;
    step();
    chk("gm_idle", st(), 8'h0);

    // Stop dropped during EXTEND
    extend_claws = 1; stop = 1;
    step();
    stop = 0;
    step();
    chk("ab_retract", st(), 8'h3);
    chk("ab_ret_outs", outs(), 8'h11);
    step();
    chk("ab_ret_hold", st(), 8'h3);
    limit_ret = 1;
    step();
    chk("ab_fault", st(), 8'h5);
    extend_claws = 0; limit_ret = 0;
    step();
    chk("ab_idle", st(), 8'h0);

    // Reset mid-RETRACT, then both limits in EXTEND
    extend_claws = 1; stop = 1;
    step();
    limit_ext = 1;
    step();
    limit_ext = 0; grip_sensor = 1;
    step(4);
    chk("rr_retract", st(), 8'h3);
    rst = 1;
    step();
    chk("rr_state", st(), 8'h0);
    chk("rr_outs", outs(), 8'h00);
    rst = 0;
    step();
    chk("bl_extend", st(), 8'h1);
    limit_ext = 1; limit_ret = 1;
    step();
    chk("bl_fault", st(), 8'h5);
    chk("bl_fault_outs", outs(), 8'h03);
    extend_claws = 0; limit_ext = 0; limit_ret = 0;
    step();
    chk("bl_idle", st(), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
